// File: rtl/sprite_blitter_if.sv
// Bus bundle for sprite_blitter: CPU draw request/status, RAM read port and VRAM pixel port.
// The master modport is the blitter itself; slave is the surrounding CPU/RAM/VRAM side.
interface sprite_blitter_if #(
  parameter int ADDR_W = 12,
  parameter int HPOS_W = 7,
  parameter int VPOS_W = 6
);
  logic              start;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [3:0]        n;
  logic [ADDR_W-1:0] base;
  logic              busy;
  logic              done;
  logic              collision;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_dout;

  logic [HPOS_W-1:0] vram_hpos;
  logic [VPOS_W-1:0] vram_vpos;
  logic [1:0]        vram_pixelo;
  logic [1:0]        vram_pixeli;
  logic              vram_we;

  modport master (
    input  start, x, y, n, base, mem_dout, vram_pixelo,
    output busy, done, collision, mem_addr, mem_rd,
           vram_hpos, vram_vpos, vram_pixeli, vram_we
  );

  modport slave (
    output start, x, y, n, base, mem_dout, vram_pixelo,
    input  busy, done, collision, mem_addr, mem_rd,
           vram_hpos, vram_vpos, vram_pixeli, vram_we
  );
endinterface

// File: rtl/sprite_blitter.sv
// XOR sprite draw engine (DXYN / DXY0): fetches sprite bytes from RAM and read-modify-writes
// a 2-bit VRAM. Define SPRITE_WRAP_EN to wrap off-edge pixels; otherwise they are clipped.
module sprite_blitter #(
  parameter int ADDR_W = 12,
  parameter int HPOS_W = 7,
  parameter int VPOS_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  sprite_blitter_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PIXEL,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [HPOS_W-1:0] x0_q, x0_d;
  logic [VPOS_W-1:0] y0_q, y0_d;
  logic [3:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        row_q, row_d;
  logic              half_q, half_d;
  logic [2:0]        col_q, col_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              collision_q, collision_d;

  logic              wide;
  logic              last_row;
  logic              last_half;
  logic [4:0]        byte_idx;
  logic [ADDR_W-1:0] fetch_addr;
  logic [HPOS_W:0]   col_sum;
  logic [VPOS_W:0]   row_sum;
  logic              on_screen;
  logic              pixel_set;

  // Geometry: n==0 selects the 16x16 sprite, whose rows are two bytes (hi byte first).
  always_comb begin
    wide       = (n_q == 4'd0);
    last_row   = (row_q == n_q - 4'd1);
    last_half  = !wide || half_q;
    byte_idx   = wide ? {row_q, half_q} : {1'b0, row_q};
    fetch_addr = base_q + ADDR_W'(byte_idx);
    col_sum    = {1'b0, x0_q} + (HPOS_W+1)'({half_q, col_q});
    row_sum    = {1'b0, y0_q} + (VPOS_W+1)'(row_q);
`ifdef SPRITE_WRAP_EN
    on_screen  = 1'b1;
`else
    on_screen  = !col_sum[HPOS_W] && !row_sum[VPOS_W];
`endif
    pixel_set  = (bus.vram_pixelo != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      n_q         <= '0;
      base_q      <= '0;
      row_q       <= '0;
      half_q      <= 1'b0;
      col_q       <= '0;
      shreg_q     <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      n_q         <= n_d;
      base_q      <= base_d;
      row_q       <= row_d;
      half_q      <= half_d;
      col_q       <= col_d;
      shreg_q     <= shreg_d;
      collision_q <= collision_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    n_d         = n_q;
    base_d      = base_q;
    row_d       = row_q;
    half_d      = half_q;
    col_d       = col_q;
    shreg_d     = shreg_q;
    collision_d = collision_q;

    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.collision   = collision_q;
    bus.mem_addr    = '0;
    bus.mem_rd      = 1'b0;
    bus.vram_hpos   = '0;
    bus.vram_vpos   = '0;
    bus.vram_pixeli = 2'b00;
    bus.vram_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x0_d        = HPOS_W'(bus.x);
          y0_d        = VPOS_W'(bus.y);
          n_d         = bus.n;
          base_d      = bus.base;
          row_d       = '0;
          half_d      = 1'b0;
          col_d       = '0;
          collision_d = 1'b0;
          state_d     = S_FETCH;
        end
      end

      S_FETCH: begin
        bus.busy     = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = fetch_addr;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        bus.busy = 1'b1;
        shreg_d  = bus.mem_dout;
        col_d    = '0;
        state_d  = S_PIXEL;
      end

      S_PIXEL: begin
        bus.busy      = 1'b1;
        bus.vram_hpos = HPOS_W'(col_sum);
        bus.vram_vpos = VPOS_W'(row_sum);
        // Clipped pixels still burn their cycle so draw time is geometry-independent.
        if (shreg_q[7] && on_screen) begin
          bus.vram_we     = 1'b1;
          bus.vram_pixeli = pixel_set ? 2'b00 : 2'b11;
          if (pixel_set) begin
            collision_d = 1'b1;
          end
        end
        shreg_d = {shreg_q[6:0], 1'b0};
        col_d   = col_q + 3'd1;
        if (col_q == 3'd7) begin
          if (last_row && last_half) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            if (wide && !half_q) begin
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              row_d  = row_q + 4'd1;
            end
          end
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: RAM/VRAM models plus a scoreboard of expected
// RAM reads and VRAM writes produced by a reference draw model.
`timescale 1ns/1ps
module tb_sprite_blitter;
  localparam int ADDR_W = 12;
  localparam int HPOS_W = 7;
  localparam int VPOS_W = 6;
  localparam int SCR_W  = 128;
  localparam int SCR_H  = 64;
`ifdef SPRITE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_blitter_if #(.ADDR_W(ADDR_W), .HPOS_W(HPOS_W), .VPOS_W(VPOS_W)) bif ();

  sprite_blitter #(.ADDR_W(ADDR_W), .HPOS_W(HPOS_W), .VPOS_W(VPOS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  typedef struct packed {
    logic [6:0] h;
    logic [5:0] v;
    logic [1:0] p;
  } wr_t;

  logic [7:0] ram      [0:4095];
  logic [1:0] vram     [0:8191];
  logic [1:0] ref_vram [0:8191];
  bit         clr_req = 1'b0;

  wr_t         wr_q[$];
  logic [11:0] rd_q[$];
  wr_t         exp_w;
  logic [11:0] exp_a;
  int tests = 0;
  int fails = 0;
  int we_cnt = 0;

  assign bif.vram_pixelo = vram[{bif.vram_vpos, bif.vram_hpos}];

  always @(posedge clk) begin
    bif.mem_dout <= ram[bif.mem_addr];
    if (clr_req) begin
      for (int i = 0; i < 8192; i++) vram[i] <= 2'b00;
    end else if (bif.vram_we) begin
      vram[{bif.vram_vpos, bif.vram_hpos}] <= bif.vram_pixeli;
    end
  end

  // Scoreboard monitor: every RAM read and VRAM write must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.mem_rd === 1'b1) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected got addr=%h required none", bif.mem_addr);
        end else begin
          exp_a = rd_q.pop_front();
          if (bif.mem_addr !== exp_a) begin
            fails++;
            $display("FAIL rd_addr got=%h required=%h", bif.mem_addr, exp_a);
          end
        end
      end
      if (bif.vram_we === 1'b1) begin
        we_cnt++;
        tests++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected got h=%0d v=%0d p=%0d required none",
                   bif.vram_hpos, bif.vram_vpos, bif.vram_pixeli);
        end else begin
          exp_w = wr_q.pop_front();
          if (bif.vram_hpos !== exp_w.h || bif.vram_vpos !== exp_w.v || bif.vram_pixeli !== exp_w.p) begin
            fails++;
            $display("FAIL wr_data got h=%0d v=%0d p=%0d required h=%0d v=%0d p=%0d",
                     bif.vram_hpos, bif.vram_vpos, bif.vram_pixeli, exp_w.h, exp_w.v, exp_w.p);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_screens();
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    for (int i = 0; i < 8192; i++) ref_vram[i] = 2'b00;
  endtask

  task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                            input logic [11:0] base, output bit coll, output int nwr);
    int rows, bpr, x0, y0;
    rows = (n == 0) ? 16 : int'(n);
    bpr  = (n == 0) ? 2 : 1;
    x0   = int'(x) % SCR_W;
    y0   = int'(y) % SCR_H;
    coll = 1'b0;
    nwr  = 0;
    for (int r = 0; r < rows; r++) begin
      for (int k = 0; k < bpr; k++) begin
        logic [11:0] a;
        logic [7:0]  b;
        a = base + 12'(r * bpr + k);
        rd_q.push_back(a);
        b = ram[a];
        for (int c = 0; c < 8; c++) begin
          if (b[7-c]) begin
            int col, row, idx;
            bit on;
            wr_t w;
            col = x0 + 8 * k + c;
            row = y0 + r;
            if (WRAP) begin
              on  = 1'b1;
              col = col % SCR_W;
              row = row % SCR_H;
            end else begin
              on = (col < SCR_W) && (row < SCR_H);
            end
            if (on) begin
              idx = row * SCR_W + col;
              w.h = 7'(col);
              w.v = 6'(row);
              if (ref_vram[idx] != 2'b00) begin
                coll = 1'b1;
                w.p  = 2'b00;
              end else begin
                w.p  = 2'b11;
              end
              ref_vram[idx] = w.p;
              wr_q.push_back(w);
              nwr++;
            end
          end
        end
      end
    end
  endtask

  // One draw transaction: model, start, latency/collision/write-count checks.
  task automatic run_draw(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] n, input logic [11:0] base, input int accept_exp,
                          input int glitch_at, input int rst_at, input bit tail);
    bit coll;
    int nwr, bytes, cnt, wait_cnt;
    model_draw(x, y, n, base, coll, nwr);
    bytes = (n == 0) ? 32 : int'(n);
    we_cnt = 0;
    bif.x = x; bif.y = y; bif.n = n; bif.base = base; bif.start = 1'b1;
    wait_cnt = 0;
    do begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end while (bif.busy !== 1'b1 && wait_cnt < 4);
    bif.start = 1'b0;
    bif.x = x ^ 8'h55; bif.y = y ^ 8'h2a; bif.n = n ^ 4'h6; bif.base = base ^ 12'h0f0;
    tests++;
    if (wait_cnt != accept_exp) begin
      fails++;
      $display("FAIL %s accept_wait got=%0d required=%0d", name, wait_cnt, accept_exp);
    end
    cnt = 0;
    while (cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == rst_at) begin
        rst_n = 1'b0;
        #1;
        tests++;
        if (bif.busy !== 1'b0 || bif.vram_we !== 1'b0 || bif.mem_rd !== 1'b0) begin
          fails++;
          $display("FAIL %s reset_drop got busy=%b we=%b rd=%b required 0 0 0",
                   name, bif.busy, bif.vram_we, bif.mem_rd);
        end
        wr_q.delete();
        rd_q.delete();
        $display("[TB] draw %s aborted by reset at cycle %0d, writes=%0d", name, cnt, we_cnt);
        return;
      end
      bif.start = (cnt == glitch_at);
      if (bif.done === 1'b1) break;
    end
    bif.start = 1'b0;
    tests++;
    if (cnt != 10 * bytes || bif.done !== 1'b1) begin
      fails++;
      $display("FAIL %s done_latency got=%0d required=%0d", name, cnt, 10 * bytes);
    end
    tests++;
    if (bif.busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_at_done got=%b required=0", name, bif.busy);
    end
    tests++;
    if (bif.collision !== coll) begin
      fails++;
      $display("FAIL %s collision got=%b required=%b", name, bif.collision, coll);
    end
    tests++;
    if (we_cnt != nwr) begin
      fails++;
      $display("FAIL %s write_count got=%0d required=%0d", name, we_cnt, nwr);
    end
    $display("[TB] draw %s x=%0d y=%0d n=%0d base=%h cycles=%0d writes=%0d coll=%b",
             name, x, y, n, base, cnt, we_cnt, bif.collision);
    if (tail) begin
      int extra_done, extra_busy;
      extra_done = 0;
      extra_busy = 0;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (bif.done !== 1'b0) extra_done++;
        if (bif.busy !== 1'b0) extra_busy++;
      end
      tests++;
      if (extra_done != 0 || extra_busy != 0) begin
        fails++;
        $display("FAIL %s after_done got done=%0d busy=%0d cycles required 0 0", name, extra_done, extra_busy);
      end
      tests++;
      if (wr_q.size() != 0 || rd_q.size() != 0) begin
        fails++;
        $display("FAIL %s queue_left got wr=%0d rd=%0d required 0 0", name, wr_q.size(), rd_q.size());
      end
    end
  endtask

  task automatic test_reset();
    bif.start = 1'b0; bif.x = '0; bif.y = '0; bif.n = '0; bif.base = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    rst_n = 1'b0;
    clear_screens();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.collision !== 1'b0 ||
        bif.mem_rd !== 1'b0 || bif.vram_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got busy=%b done=%b coll=%b rd=%b we=%b required all 0",
               bif.busy, bif.done, bif.collision, bif.mem_rd, bif.vram_we);
    end
    tests++;
    if (bif.mem_addr !== 12'h000 || bif.vram_hpos !== 7'd0 || bif.vram_vpos !== 6'd0 || bif.vram_pixeli !== 2'b00) begin
      fails++;
      $display("FAIL reset_addr got addr=%h h=%0d v=%0d pi=%0d required 0", bif.mem_addr,
               bif.vram_hpos, bif.vram_vpos, bif.vram_pixeli);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pixel();
    ram[12'h300] = 8'h80;
    run_draw("single", 8'd0, 8'd0, 4'd1, 12'h300, 1, 0, 0, 1);
    tests++;
    if (vram[0] !== 2'd3 || bif.collision !== 1'b0 || we_cnt != 1) begin
      fails++;
      $display("FAIL single_pixel got pix=%0d coll=%b we=%0d required 3 0 1", vram[0], bif.collision, we_cnt);
    end
    run_draw("redraw", 8'd0, 8'd0, 4'd1, 12'h300, 1, 0, 0, 1);
    tests++;
    if (vram[0] !== 2'd0 || bif.collision !== 1'b1 || we_cnt != 1) begin
      fails++;
      $display("FAIL redraw got pix=%0d coll=%b we=%0d required 0 1 1", vram[0], bif.collision, we_cnt);
    end
  endtask

  task automatic test_edge();
    logic [1:0] wrap_pix;
    wrap_pix = WRAP ? 2'd3 : 2'd0;
    clear_screens();
    ram[12'h310] = 8'hff;
    run_draw("edge_x", 8'd126, 8'd0, 4'd1, 12'h310, 1, 0, 0, 1);
    tests++;
    if (vram[126] !== 2'd3 || vram[127] !== 2'd3 || vram[6] !== 2'd0) begin
      fails++;
      $display("FAIL edge_cols got c126=%0d c127=%0d c6=%0d required 3 3 0", vram[126], vram[127], vram[6]);
    end
    tests++;
    if (vram[0] !== wrap_pix || vram[5] !== wrap_pix || we_cnt != (WRAP ? 8 : 2)) begin
      fails++;
      $display("FAIL edge_wrap got c0=%0d c5=%0d we=%0d required %0d %0d %0d",
               vram[0], vram[5], we_cnt, wrap_pix, wrap_pix, WRAP ? 8 : 2);
    end
    clear_screens();
    for (int i = 0; i < 4; i++) ram[12'h320 + 12'(i)] = 8'h80;
    run_draw("edge_y", 8'd128, 8'd126, 4'd4, 12'h320, 1, 0, 0, 1);
    tests++;
    if (vram[62*SCR_W] !== 2'd3 || vram[63*SCR_W] !== 2'd3 || vram[SCR_W] !== wrap_pix || we_cnt != (WRAP ? 4 : 2)) begin
      fails++;
      $display("FAIL edge_rows got r62=%0d r63=%0d r1=%0d we=%0d required 3 3 %0d %0d",
               vram[62*SCR_W], vram[63*SCR_W], vram[SCR_W], we_cnt, wrap_pix, WRAP ? 4 : 2);
    end
  endtask

  task automatic test_big_sprite();
    int bad;
    clear_screens();
    for (int i = 0; i < 32; i++) ram[12'h400 + 12'(i)] = 8'($urandom_range(0, 255));
    ram[12'h400] = 8'hff;
    run_draw("big16", 8'd20, 8'd10, 4'd0, 12'h400, 1, 0, 0, 1);
    bad = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (vram[(10 + r) * SCR_W + 20 + c] !== ref_vram[(10 + r) * SCR_W + 20 + c]) bad++;
    tests++;
    if (bad != 0 || vram[10*SCR_W + 27] !== 2'd3) begin
      fails++;
      $display("FAIL big16_block got %0d bad pixels corner=%0d required 0 3", bad, vram[10*SCR_W + 27]);
    end
    // Overlapping redraw of a smaller sprite exercises collision with prior content.
    ram[12'h440] = 8'hf0; ram[12'h441] = 8'h3c;
    run_draw("overlap", 8'd22, 8'd11, 4'd2, 12'h440, 1, 0, 0, 1);
  endtask

  task automatic test_start_ignored();
    clear_screens();
    ram[12'h330] = 8'ha5; ram[12'h331] = 8'h5a; ram[12'h332] = 8'hc3;
    run_draw("glitch", 8'd40, 8'd5, 4'd3, 12'h330, 1, 3, 0, 1);
  endtask

  task automatic test_back_to_back();
    clear_screens();
    ram[12'h340] = 8'h81; ram[12'h350] = 8'h18;
    run_draw("b2b_a", 8'd60, 8'd30, 4'd1, 12'h340, 1, 0, 0, 0);
    run_draw("b2b_b", 8'd60, 8'd30, 4'd1, 12'h350, 2, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    clear_screens();
    for (int i = 0; i < 5; i++) ram[12'h360 + 12'(i)] = 8'hff;
    run_draw("rst_mid", 8'd70, 8'd40, 4'd5, 12'h360, 1, 0, 25, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_screens();
    tests++;
    if (bif.busy !== 1'b0 || bif.collision !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_idle got busy=%b coll=%b required 0 0", bif.busy, bif.collision);
    end
    run_draw("post_rst", 8'd70, 8'd40, 4'd5, 12'h360, 1, 0, 0, 1);
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_edge();
    test_big_sprite();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
